// File: rtl/mux_n_to_1_scan.sv
// ---------------------------------------------------------------------------
// mux_n_to_1_scan
//
// Registered N-to-1 time-multiplexer for the seven-segment LED path. A
// prescaler divides CLK into scan slots. In auto mode the channel index
// advances once per slot to the next enabled channel. In manual mode the
// index follows MAN_SEL. The selected word and a one-hot digit select are
// registered onto the display pins.
//
// Optional feature macro: SCAN_DEADTIME_EN
//   When defined, SEL_ONEHOT is held at zero for the first part of every slot
//   to suppress ghosting while the segment data changes over.
//   When undefined, SEL_ONEHOT is valid for the whole slot.
//
// Parameters
//   WIDTH     bits per channel word
//   CHANNELS  number of input channels (>= 2)
//   SEL_W     index width, = $clog2(CHANNELS)
//   PRESCALE  CLK cycles per scan slot (>= 4)
//
// Ports
//   CLK          in   system clock, rising edge
//   RESETN       in   synchronous reset, active-low
//   IN_BUS       in   channel k at bits [k*WIDTH +: WIDTH]
//   CH_EN        in   per-channel enable mask
//   MODE         in   0 = auto scan, 1 = manual select
//   MAN_SEL      in   channel index used in manual mode
//   OUT          out  selected channel word (registered)
//   SEL_ONEHOT   out  active-high one-hot digit select (registered)
//   SEL_IDX      out  current channel index (registered)
//   SLOT_STROBE  out  one-cycle pulse at each slot boundary
// ---------------------------------------------------------------------------
module mux_n_to_1_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int PRESCALE = 100000
) (
    input  logic                      CLK,
    input  logic                      RESETN,
    input  logic [CHANNELS*WIDTH-1:0] IN_BUS,
    input  logic [CHANNELS-1:0]       CH_EN,
    input  logic                      MODE,
    input  logic [SEL_W-1:0]          MAN_SEL,
    output logic [WIDTH-1:0]          OUT,
    output logic [CHANNELS-1:0]       SEL_ONEHOT,
    output logic [SEL_W-1:0]          SEL_IDX,
    output logic                      SLOT_STROBE
);

    localparam int PW = $clog2(PRESCALE);

    // The dead-time window is PRESCALE/8 cycles, but never shorter than one
    // cycle, so that small prescalers still get a blanked first cycle.
    localparam int DEAD_RAW    = PRESCALE >> 3;
    localparam int DEAD_CYCLES = (DEAD_RAW > 0) ? DEAD_RAW : 1;

    logic [PW-1:0]        presc_q, presc_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic [CHANNELS-1:0]  onehot_q, onehot_d;
    logic [SEL_W-1:0]     sel_idx_q, sel_idx_d;
    logic                 strobe_q, strobe_d;

    logic                 tc;
    logic                 man_valid;
    logic                 found;
    logic [SEL_W-1:0]     next_auto;
    logic [SEL_W-1:0]     cand_idx;
    logic [SEL_W-1:0]     eff_idx;
    logic                 blank;
    int                   cand;
    logic [WIDTH-1:0]     words [CHANNELS];

    // MAN_SEL can only be out of range when CHANNELS is not a power of two.
    generate
        if (CHANNELS == (1 << SEL_W)) begin : g_sel_full
            assign man_valid = 1'b1;
        end else begin : g_sel_partial
            assign man_valid = (MAN_SEL <= SEL_W'(CHANNELS - 1));
        end
    endgenerate

    assign tc = (presc_q == PW'(PRESCALE - 1));

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            words[k] = IN_BUS[k*WIDTH +: WIDTH];
        end
    end

    // Round-robin search for the next enabled channel after idx_q. If no
    // other channel is enabled the index stays where it is.
    always_comb begin
        next_auto = idx_q;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i < CHANNELS; i++) begin
            cand = int'(idx_q) + i;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            cand_idx = SEL_W'(cand);
            if (!found && CH_EN[cand_idx]) begin
                found     = 1'b1;
                next_auto = cand_idx;
            end
        end
    end

    // Next-state logic. In manual mode the outputs follow a valid MAN_SEL
    // directly, so the display reacts one cycle after the select changes.
    // In auto mode the outputs follow the stored index, one cycle behind it.
    always_comb begin
        presc_d  = tc ? '0 : presc_q + 1'b1;
        strobe_d = tc;

        idx_d   = idx_q;
        eff_idx = idx_q;
        blank   = 1'b0;
        if (MODE) begin
            if (man_valid) begin
                idx_d   = MAN_SEL;
                eff_idx = MAN_SEL;
            end else begin
                blank = 1'b1;
            end
        end else if (tc) begin
            idx_d = next_auto;
        end

        if (!CH_EN[eff_idx]) begin
            blank = 1'b1;
        end

        sel_idx_d = eff_idx;
        out_d     = blank ? '0 : words[eff_idx];
        onehot_d  = blank ? '0 : (CHANNELS'(1) << eff_idx);

`ifdef SCAN_DEADTIME_EN
        // Blank the digit select while the slot is young; the registered
        // output lines this window up with the first cycles of the new word.
        if (presc_q < PW'(DEAD_CYCLES)) begin
            onehot_d = '0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            presc_q   <= '0;
            idx_q     <= '0;
            out_q     <= '0;
            onehot_q  <= '0;
            sel_idx_q <= '0;
            strobe_q  <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            out_q     <= out_d;
            onehot_q  <= onehot_d;
            sel_idx_q <= sel_idx_d;
            strobe_q  <= strobe_d;
        end
    end

    assign OUT         = out_q;
    assign SEL_ONEHOT  = onehot_q;
    assign SEL_IDX     = sel_idx_q;
    assign SLOT_STROBE = strobe_q;

endmodule
